// File: rtl/slot_cycle_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | slot_cycle_sequencer: runs one MSX slot bus cycle (mem/IO, rd/wr) per req  |
// | Revision 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module slot_cycle_sequencer #(
    parameter int SETUP_CYCLES  = 2,
    parameter int STROBE_CYCLES = 4,
    parameter int HOLD_CYCLES   = 1,
    parameter int WAIT_TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic        req_io,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_timeout,
    output logic        busy,
    output logic [15:0] slot_a,
    output logic        slot_nrd,
    output logic        slot_nwr,
    output logic        slot_niorq,
    output logic        slot_nmerq,
    input  logic        slot_nwait,
    input  logic [7:0]  slot_d_in,
    output logic [7:0]  cpu_ff_slot_data,
    output logic        cpu_drive_en
);

    localparam logic [7:0] SETUP_LOAD  = 8'(SETUP_CYCLES - 1);
    localparam logic [7:0] STROBE_LOAD = 8'(STROBE_CYCLES - 1);
    localparam logic [7:0] HOLD_LOAD   = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] WAIT_LOAD   = 8'(WAIT_TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_WAIT   = 3'd3,
        ST_HOLD   = 3'd4,
        ST_RESP   = 3'd5
    } state_t;

    state_t      state, state_nx;
    logic [7:0]  cnt, cnt_nx;
    logic        timeout_q, timeout_nx;
    logic        sample_en;
    logic        nwait_s1, nwait_s2;
    logic        write_q, io_q;
    logic [15:0] addr_q;
    logic [7:0]  wdata_q;
    logic [7:0]  rdata_q;

    logic        accept;
    logic        cur_write, cur_io;
    logic [15:0] cur_addr;
    logic [7:0]  cur_wdata;

    logic        nrd_nx, nwr_nx, niorq_nx, nmerq_nx, drive_nx;
    logic [15:0] addr_nx;
    logic [7:0]  dout_nx;
    logic        rsp_valid_nx, rsp_timeout_nx;
    logic [7:0]  rsp_rdata_nx;

    assign accept    = (state == ST_IDLE) && req_valid;
    assign cur_write = accept ? req_write : write_q;
    assign cur_io    = accept ? req_io    : io_q;
    assign cur_addr  = accept ? req_addr  : addr_q;
    assign cur_wdata = accept ? req_wdata : wdata_q;

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt - 8'd1;
        timeout_nx = timeout_q;
        sample_en  = 1'b0;
        case (state)
            ST_IDLE: begin
                cnt_nx = cnt;
                if (req_valid) begin
                    state_nx   = ST_SETUP;
                    cnt_nx     = SETUP_LOAD;
                    timeout_nx = 1'b0;
                end
            end
            ST_SETUP: begin
                if (cnt == 8'd0) begin
                    state_nx = ST_STROBE;
                    cnt_nx   = STROBE_LOAD;
                end
            end
            ST_STROBE: begin
                if (cnt == 8'd0) begin
                    if (!nwait_s2) begin
                        state_nx = ST_WAIT;
                        cnt_nx   = WAIT_LOAD;
                    end else begin
                        state_nx  = ST_HOLD;
                        cnt_nx    = HOLD_LOAD;
                        sample_en = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                // A released wait wins over a timeout expiring in the same cycle.
                if (nwait_s2) begin
                    state_nx  = ST_HOLD;
                    cnt_nx    = HOLD_LOAD;
                    sample_en = 1'b1;
                end else if (cnt == 8'd0) begin
                    state_nx   = ST_HOLD;
                    cnt_nx     = HOLD_LOAD;
                    timeout_nx = 1'b1;
                end
            end
            ST_HOLD: begin
                if (cnt == 8'd0) begin
                    state_nx = ST_RESP;
                    cnt_nx   = 8'd0;
                end
            end
            ST_RESP: begin
                state_nx = ST_IDLE;
                cnt_nx   = 8'd0;
            end
            default: begin
                state_nx = ST_IDLE;
                cnt_nx   = 8'd0;
            end
        endcase
    end

    // Outputs are decoded from the next state so every bus pin comes from a flop.
    always_comb begin
        nrd_nx         = 1'b1;
        nwr_nx         = 1'b1;
        niorq_nx       = 1'b1;
        nmerq_nx       = 1'b1;
        drive_nx       = 1'b0;
        addr_nx        = slot_a;
        dout_nx        = cpu_ff_slot_data;
        rsp_valid_nx   = 1'b0;
        rsp_rdata_nx   = rsp_rdata;
        rsp_timeout_nx = rsp_timeout;
        case (state_nx)
            ST_SETUP, ST_STROBE, ST_WAIT, ST_HOLD: begin
                addr_nx  = cur_addr;
                niorq_nx = !cur_io;
                nmerq_nx = cur_io;
                drive_nx = cur_write;
                if (cur_write) begin
                    dout_nx = cur_wdata;
                end
                if ((state_nx == ST_STROBE) || (state_nx == ST_WAIT)) begin
                    nrd_nx = cur_write;
                    nwr_nx = !cur_write;
                end
            end
            ST_RESP: begin
                rsp_valid_nx   = 1'b1;
                rsp_timeout_nx = timeout_q;
                rsp_rdata_nx   = write_q ? 8'h00 : (timeout_q ? 8'hFF : rdata_q);
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= ST_IDLE;
            cnt              <= 8'd0;
            timeout_q        <= 1'b0;
            nwait_s1         <= 1'b1;
            nwait_s2         <= 1'b1;
            write_q          <= 1'b0;
            io_q             <= 1'b0;
            addr_q           <= 16'h0000;
            wdata_q          <= 8'h00;
            rdata_q          <= 8'h00;
            req_ready        <= 1'b1;
            busy             <= 1'b0;
            slot_a           <= 16'h0000;
            slot_nrd         <= 1'b1;
            slot_nwr         <= 1'b1;
            slot_niorq       <= 1'b1;
            slot_nmerq       <= 1'b1;
            cpu_ff_slot_data <= 8'h00;
            cpu_drive_en     <= 1'b0;
            rsp_valid        <= 1'b0;
            rsp_rdata        <= 8'h00;
            rsp_timeout      <= 1'b0;
        end else begin
            state            <= state_nx;
            cnt              <= cnt_nx;
            timeout_q        <= timeout_nx;
            nwait_s1         <= slot_nwait;
            nwait_s2         <= nwait_s1;
            if (accept) begin
                write_q <= req_write;
                io_q    <= req_io;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (sample_en) begin
                rdata_q <= slot_d_in;
            end
            req_ready        <= (state_nx == ST_IDLE);
            busy             <= (state_nx != ST_IDLE);
            slot_a           <= addr_nx;
            slot_nrd         <= nrd_nx;
            slot_nwr         <= nwr_nx;
            slot_niorq       <= niorq_nx;
            slot_nmerq       <= nmerq_nx;
            cpu_ff_slot_data <= dout_nx;
            cpu_drive_en     <= drive_nx;
            rsp_valid        <= rsp_valid_nx;
            rsp_rdata        <= rsp_rdata_nx;
            rsp_timeout      <= rsp_timeout_nx;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_slot_cycle_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_slot_cycle_sequencer: directed bench for slot_cycle_sequencer           |
// | Revision 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module tb_slot_cycle_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    int          checks = 0;
    int          errors = 0;
    logic        tb_read = 1'b0;

    logic        req_valid = 1'b0, req_write = 1'b0, req_io = 1'b0;
    logic [15:0] req_addr = 16'h0;
    logic [7:0]  req_wdata = 8'h0, slot_d_in = 8'h0;
    logic        slot_nwait = 1'b1;
    logic        req_ready, rsp_valid, rsp_timeout, busy;
    logic [7:0]  rsp_rdata, cpu_ff_slot_data;
    logic [15:0] slot_a;
    logic        slot_nrd, slot_nwr, slot_niorq, slot_nmerq, cpu_drive_en;

    logic        t_req_valid = 1'b0;
    logic [7:0]  t_slot_d_in = 8'h33;
    logic        t_slot_nwait = 1'b0;
    logic        t_req_ready, t_rsp_valid, t_rsp_timeout, t_busy;
    logic [7:0]  t_rsp_rdata, t_ff;
    logic [15:0] t_slot_a;
    logic        t_nrd, t_nwr, t_niorq, t_nmerq, t_drive;

    always #5 clk = ~clk;

    slot_cycle_sequencer u_dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_io(req_io), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout),
        .busy(busy), .slot_a(slot_a), .slot_nrd(slot_nrd), .slot_nwr(slot_nwr),
        .slot_niorq(slot_niorq), .slot_nmerq(slot_nmerq), .slot_nwait(slot_nwait),
        .slot_d_in(slot_d_in), .cpu_ff_slot_data(cpu_ff_slot_data),
        .cpu_drive_en(cpu_drive_en)
    );

    slot_cycle_sequencer #(.WAIT_TIMEOUT(4)) u_to (
        .clk(clk), .reset_n(reset_n),
        .req_valid(t_req_valid), .req_ready(t_req_ready), .req_write(1'b0),
        .req_io(1'b0), .req_addr(16'h7000), .req_wdata(8'h00),
        .rsp_valid(t_rsp_valid), .rsp_rdata(t_rsp_rdata), .rsp_timeout(t_rsp_timeout),
        .busy(t_busy), .slot_a(t_slot_a), .slot_nrd(t_nrd), .slot_nwr(t_nwr),
        .slot_niorq(t_niorq), .slot_nmerq(t_nmerq), .slot_nwait(t_slot_nwait),
        .slot_d_in(t_slot_d_in), .cpu_ff_slot_data(t_ff), .cpu_drive_en(t_drive)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chkv(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Bus invariants watched on every falling edge.
    always @(negedge clk) begin
        if (reset_n) begin
            checks++;
            assert (!(slot_nrd === 1'b0 && slot_nwr === 1'b0)) else begin
                errors++;
                $error("FAIL inv_rd_wr observed nrd=%b nwr=%b expected not both 0", slot_nrd, slot_nwr);
            end
            if (tb_read) begin
                checks++;
                assert (cpu_drive_en === 1'b0) else begin
                    errors++;
                    $error("FAIL inv_drive_rd observed=%b expected=0", cpu_drive_en);
                end
            end
        end
    end

    initial begin
        // Reset values, checked before any clock edge to show the reset is asynchronous
        #1 reset_n = 1'b0;
        #2;
        chk1("rst_nrd", slot_nrd, 1'b1);
        chk1("rst_nwr", slot_nwr, 1'b1);
        chk1("rst_niorq", slot_niorq, 1'b1);
        chk1("rst_nmerq", slot_nmerq, 1'b1);
        chk1("rst_drive", cpu_drive_en, 1'b0);
        chkv("rst_slot_a", slot_a, 16'h0000);
        chkv("rst_ff_data", 16'(cpu_ff_slot_data), 16'h0000);
        chk1("rst_rsp_valid", rsp_valid, 1'b0);
        chkv("rst_rdata", 16'(rsp_rdata), 16'h0000);
        chk1("rst_timeout", rsp_timeout, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_ready", req_ready, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        step();

        // Memory read with defaults
        tb_read = 1'b1;
        req_write = 1'b0; req_io = 1'b0; req_addr = 16'h4000; slot_d_in = 8'h5A;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            chk1("rd_nmerq", slot_nmerq, !(c <= 7));
            chk1("rd_niorq", slot_niorq, 1'b1);
            chk1("rd_nrd", slot_nrd, !(c >= 3 && c <= 6));
            chk1("rd_nwr", slot_nwr, 1'b1);
            chk1("rd_drive", cpu_drive_en, 1'b0);
            chk1("rd_rsp_valid", rsp_valid, c == 8);
            chk1("rd_busy", busy, c <= 8);
            chk1("rd_ready", req_ready, c == 9);
            if (c <= 7) chkv("rd_slot_a", slot_a, 16'h4000);
            if (c == 8) begin
                chkv("rd_rdata", 16'(rsp_rdata), 16'h005A);
                chk1("rd_timeout", rsp_timeout, 1'b0);
            end
            if (c < 9) step();
        end

        // I/O write
        tb_read = 1'b0;
        req_write = 1'b1; req_io = 1'b1; req_addr = 16'h0098; req_wdata = 8'hC3;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            chk1("wr_niorq", slot_niorq, !(c <= 7));
            chk1("wr_nmerq", slot_nmerq, 1'b1);
            chk1("wr_nwr", slot_nwr, !(c >= 3 && c <= 6));
            chk1("wr_nrd", slot_nrd, 1'b1);
            chk1("wr_drive", cpu_drive_en, c <= 7);
            chkv("wr_ff_data", 16'(cpu_ff_slot_data), 16'h00C3);
            chkv("wr_slot_a", slot_a, 16'h0098);
            chk1("wr_rsp_valid", rsp_valid, c == 8);
            if (c == 8) chkv("wr_rdata", 16'(rsp_rdata), 16'h0000);
            if (c < 9) step();
        end

        // Wait extension: nwait low in cycles 1..9, data changes every cycle
        tb_read = 1'b1;
        req_write = 1'b0; req_io = 1'b0; req_addr = 16'h8123;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        for (int c = 1; c <= 15; c++) begin
            slot_nwait = !(c <= 9);
            slot_d_in  = 8'h10 + 8'(c);
            chk1("wt_nrd", slot_nrd, !(c >= 3 && c <= 12));
            chk1("wt_nmerq", slot_nmerq, !(c <= 13));
            chk1("wt_rsp_valid", rsp_valid, c == 14);
            chk1("wt_busy", busy, c <= 14);
            chk1("wt_ready", req_ready, c == 15);
            if (c == 14) begin
                chkv("wt_rdata", 16'(rsp_rdata), 16'h001C);
                chk1("wt_timeout", rsp_timeout, 1'b0);
            end
            if (c < 15) step();
        end

        // Timeout on the WAIT_TIMEOUT=4 instance, nwait held low
        t_req_valid = 1'b1;
        step();
        t_req_valid = 1'b0;
        for (int c = 1; c <= 13; c++) begin
            chk1("to_nrd", t_nrd, !(c >= 3 && c <= 10));
            chk1("to_rsp_valid", t_rsp_valid, c == 12);
            chk1("to_ready", t_req_ready, c == 13);
            if (c == 12) begin
                chkv("to_rdata", 16'(t_rsp_rdata), 16'h00FF);
                chk1("to_timeout", t_rsp_timeout, 1'b1);
            end
            if (c < 13) step();
        end

        // Back-to-back reads with req_valid held high
        req_write = 1'b0; req_io = 1'b0; req_addr = 16'h1234; slot_d_in = 8'hA5;
        req_valid = 1'b1;
        step();
        req_addr = 16'h2345;
        for (int c = 1; c <= 18; c++) begin
            chk1("bb_ready", req_ready, (c == 9) || (c == 18));
            chk1("bb_rsp_valid", rsp_valid, (c == 8) || (c == 17));
            chk1("bb_nmerq", slot_nmerq, !((c <= 7) || (c >= 10 && c <= 16)));
            chk1("bb_nrd", slot_nrd, !((c >= 3 && c <= 6) || (c >= 12 && c <= 15)));
            if (c == 2)  chkv("bb_addr1", slot_a, 16'h1234);
            if (c == 10) begin
                chkv("bb_addr2", slot_a, 16'h2345);
                req_valid = 1'b0;
            end
            if (c == 17) chkv("bb_rdata2", 16'(rsp_rdata), 16'h00A5);
            if (c < 18) step();
        end

        // Reset during the strobe of a write
        tb_read = 1'b0;
        req_write = 1'b1; req_io = 1'b0; req_addr = 16'h8001; req_wdata = 8'h77;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        repeat (3) step();
        chk1("mr_nwr_before", slot_nwr, 1'b0);
        #1 reset_n = 1'b0;
        #1;
        chk1("mr_nwr", slot_nwr, 1'b1);
        chk1("mr_nmerq", slot_nmerq, 1'b1);
        chk1("mr_drive", cpu_drive_en, 1'b0);
        chkv("mr_slot_a", slot_a, 16'h0000);
        chkv("mr_ff_data", 16'(cpu_ff_slot_data), 16'h0000);
        chk1("mr_busy", busy, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            chk1("mr_rsp_valid", rsp_valid, 1'b0);
            chk1("mr_ready", req_ready, 1'b1);
            chk1("mr_idle_nwr", slot_nwr, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
